cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 38 +++
 rtl/cdb_arbiter_if.sv | 51 +++++
 rtl/cdb_fifo.sv | 65 ++++++
 rtl/cdb_arbiter.sv | 144 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the common data bus arbiter.
// Holds the ROB/data/address types, the invalid ROB tag, the CDB FIFO
// depth and pointer type, and the packed queue entry layouts.
package cdb_arbiter_pkg;

  localparam int ROB_W = 5;

  typedef logic [ROB_W-1:0] rob_id_t;   // ROB_ID_TYPE
  typedef logic [31:0]      data_t;     // DATA_TYPE
  typedef logic [31:0]      addr_t;     // ADDR_TYPE

  // ROB tag 0 never names a live entry, so results carrying it are ignored.
  localparam rob_id_t INVALID_ROB = '0;

  localparam int CDB_FIFO_DEPTH = 4;
  typedef logic [1:0] cdb_ptr_t;        // CDB_PTR_TYPE, wraps 3 -> 0
  typedef logic [2:0] cdb_cnt_t;        // holds 0..CDB_FIFO_DEPTH

  // ALU result as queued: 5 + 32 + 32 + 1 = 70 bits.
  typedef struct packed {
    rob_id_t rob_id;
    data_t   data;
    addr_t   pc;
    logic    jump;
  } rs_entry_t;

  // Load/store result as queued: 5 + 32 = 37 bits.
  typedef struct packed {
    rob_id_t rob_id;
    data_t   data;
  } ls_entry_t;

  typedef enum logic {
    SRC_RS = 1'b0,
    SRC_LS = 1'b1
  } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of the arbiter's control, source-result and broadcast signals.
// slave: the arbiter side; master: the side driving results and
// consuming the broadcast.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic        rdy;
  logic        rollback_sign;

  logic        valid_from_rs_ex;
  rob_id_t     rob_id_from_rs_ex;
  data_t       data_from_rs_ex;
  addr_t       jump_target_pc_from_rs_ex;
  logic        jump_sign_from_rs_ex;

  logic        valid_from_ls_ex;
  rob_id_t     rob_id_from_ls_ex;
  data_t       data_from_ls_ex;

  logic        full_to_rs;
  logic        full_to_ls;

  logic        cdb_valid;
  rob_id_t     cdb_rob_id;
  data_t       cdb_data;
  addr_t       cdb_jump_target_pc;
  logic        cdb_jump_sign;
  logic        cdb_from_ls;
  logic [31:0] conflict_cnt;

  modport slave (
    input  rdy, rollback_sign,
    input  valid_from_rs_ex, rob_id_from_rs_ex, data_from_rs_ex,
           jump_target_pc_from_rs_ex, jump_sign_from_rs_ex,
    input  valid_from_ls_ex, rob_id_from_ls_ex, data_from_ls_ex,
    output full_to_rs, full_to_ls,
    output cdb_valid, cdb_rob_id, cdb_data, cdb_jump_target_pc,
           cdb_jump_sign, cdb_from_ls, conflict_cnt
  );

  modport master (
    output rdy, rollback_sign,
    output valid_from_rs_ex, rob_id_from_rs_ex, data_from_rs_ex,
           jump_target_pc_from_rs_ex, jump_sign_from_rs_ex,
    output valid_from_ls_ex, rob_id_from_ls_ex, data_from_ls_ex,
    input  full_to_rs, full_to_ls,
    input  cdb_valid, cdb_rob_id, cdb_data, cdb_jump_target_pc,
           cdb_jump_sign, cdb_from_ls, conflict_cnt
  );

endinterface

// File: rtl/cdb_fifo.sv
// Small per-source result queue in front of the CDB.
// Depth CDB_FIFO_DEPTH, 2-bit wrapping pointers, 3-bit occupancy.
// full_o asserts one entry early so a source that registers its
// issue decision still has a slot for the result already in flight.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output cdb_cnt_t         count_o
);

  logic [WIDTH-1:0] mem_q [CDB_FIFO_DEPTH];
  cdb_ptr_t         rptr_q, wptr_q;
  cdb_cnt_t         cnt_q;
  logic             do_push, do_pop;

  // A push into a completely full queue is lost; pop only acts on real data.
  assign do_push = push_i && (cnt_q != cdb_cnt_t'(CDB_FIFO_DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);

  // Pointer and occupancy update; flush empties the queue outright.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else if (rdy_i) begin
      if (flush_i) begin
        rptr_q <= '0;
        wptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (do_push) wptr_q <= wptr_q + 2'd1;
        if (do_pop)  rptr_q <= rptr_q + 2'd1;
        unique case ({do_push, do_pop})
          2'b10:   cnt_q <= cnt_q + 3'd1;
          2'b01:   cnt_q <= cnt_q - 3'd1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!rst && rdy_i && !flush_i && do_push) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q >= cdb_cnt_t'(CDB_FIFO_DEPTH - 1));
  assign count_o = cnt_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU (RS) and load/store (LS) results
// and broadcasts one per cycle from registered outputs. Under contention
// the two sources alternate; a lone non-empty queue is always served.
// Optional feature: define CDB_CONFLICT_CNT_EN to count contended cycles
// on conflict_cnt; otherwise conflict_cnt is tied to 0.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);

  rs_entry_t rs_din, rs_head;
  ls_entry_t ls_din, ls_head;
  logic      rs_push, ls_push, rs_pop, ls_pop;
  logic      rs_full, ls_full, rs_empty, ls_empty;
  cdb_cnt_t  rs_cnt, ls_cnt;
  logic      contend, grant_rs, grant_ls;

  cdb_src_e  prio_q;
  logic      cdb_valid_q;
  rob_id_t   cdb_rob_id_q;
  data_t     cdb_data_q;
  addr_t     cdb_pc_q;
  logic      cdb_jump_q;
  logic      cdb_from_ls_q;

  // Results tagged with the invalid ROB id, or arriving during a flush, are dropped.
  assign rs_push = bus.valid_from_rs_ex && (bus.rob_id_from_rs_ex != INVALID_ROB)
                   && !bus.rollback_sign;
  assign ls_push = bus.valid_from_ls_ex && (bus.rob_id_from_ls_ex != INVALID_ROB)
                   && !bus.rollback_sign;

  assign rs_din = '{rob_id: bus.rob_id_from_rs_ex, data: bus.data_from_rs_ex,
                    pc: bus.jump_target_pc_from_rs_ex, jump: bus.jump_sign_from_rs_ex};
  assign ls_din = '{rob_id: bus.rob_id_from_ls_ex, data: bus.data_from_ls_ex};

  cdb_fifo #(.WIDTH($bits(rs_entry_t))) u_rs_fifo (
    .clk     (clk),
    .rst     (rst),
    .rdy_i   (bus.rdy),
    .flush_i (bus.rollback_sign),
    .push_i  (rs_push),
    .din_i   (rs_din),
    .pop_i   (rs_pop),
    .dout_o  (rs_head),
    .full_o  (rs_full),
    .empty_o (rs_empty),
    .count_o (rs_cnt)
  );

  cdb_fifo #(.WIDTH($bits(ls_entry_t))) u_ls_fifo (
    .clk     (clk),
    .rst     (rst),
    .rdy_i   (bus.rdy),
    .flush_i (bus.rollback_sign),
    .push_i  (ls_push),
    .din_i   (ls_din),
    .pop_i   (ls_pop),
    .dout_o  (ls_head),
    .full_o  (ls_full),
    .empty_o (ls_empty),
    .count_o (ls_cnt)
  );

  assign contend = (rs_cnt != '0) && (ls_cnt != '0);

  // Pick at most one head: the lone non-empty queue, or prio under contention.
  always_comb begin
    grant_rs = 1'b0;
    grant_ls = 1'b0;
    if (contend) begin
      if (prio_q == SRC_RS) grant_rs = 1'b1;
      else                  grant_ls = 1'b1;
    end else if (!rs_empty) begin
      grant_rs = 1'b1;
    end else if (!ls_empty) begin
      grant_ls = 1'b1;
    end
  end

  assign rs_pop = grant_rs && !bus.rollback_sign;
  assign ls_pop = grant_ls && !bus.rollback_sign;

  // Broadcast registers and fairness bit; held whenever rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q        <= SRC_RS;
      cdb_valid_q   <= 1'b0;
      cdb_rob_id_q  <= '0;
      cdb_data_q    <= '0;
      cdb_pc_q      <= '0;
      cdb_jump_q    <= 1'b0;
      cdb_from_ls_q <= 1'b0;
    end else if (bus.rdy) begin
      if (bus.rollback_sign) begin
        prio_q      <= SRC_RS;
        cdb_valid_q <= 1'b0;
      end else begin
        cdb_valid_q <= grant_rs || grant_ls;
        if (grant_rs) begin
          cdb_rob_id_q  <= rs_head.rob_id;
          cdb_data_q    <= rs_head.data;
          cdb_pc_q      <= rs_head.pc;
          cdb_jump_q    <= rs_head.jump;
          cdb_from_ls_q <= 1'b0;
        end else if (grant_ls) begin
          cdb_rob_id_q  <= ls_head.rob_id;
          cdb_data_q    <= ls_head.data;
          cdb_pc_q      <= '0;
          cdb_jump_q    <= 1'b0;
          cdb_from_ls_q <= 1'b1;
        end
        // Hand priority to whichever source lost this contended round.
        if (contend) prio_q <= grant_rs ? SRC_LS : SRC_RS;
      end
    end
  end

`ifdef CDB_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt_q;

  // Count cycles where both queues compete for the bus; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)                                          conflict_cnt_q <= '0;
    else if (bus.rdy && !bus.rollback_sign && contend) conflict_cnt_q <= conflict_cnt_q + 32'd1;
  end

  assign bus.conflict_cnt = conflict_cnt_q;
`else
  assign bus.conflict_cnt = '0;
`endif

  assign bus.full_to_rs         = rs_full;
  assign bus.full_to_ls         = ls_full;
  assign bus.cdb_valid          = cdb_valid_q;
  assign bus.cdb_rob_id         = cdb_rob_id_q;
  assign bus.cdb_data           = cdb_data_q;
  assign bus.cdb_jump_target_pc = cdb_pc_q;
  assign bus.cdb_jump_sign      = cdb_jump_q;
  assign bus.cdb_from_ls        = cdb_from_ls_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a per-cycle vector table for
// ordering, fairness, fill/drop and flush, followed by hand-written
// sequences for the fixed-data broadcast, rollback, rdy freeze and
// mid-operation reset.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if bus();

  cdb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_cc = 0;

  typedef struct {
    logic       rdy, rb, rsv;
    logic [4:0] rsid;
    logic       lsv;
    logic [4:0] lsid;
    logic       ev;
    logic [4:0] eid;
    logic       els, efr, efl;
    int         ecc;
  } vec_t;

  vec_t tbl[$];

  // Payloads derived from the ROB id so expected data follows from the id.
  function automatic logic [31:0] rs_data(input logic [4:0] id);
    return 32'(id) * 32'h0001_0101;
  endfunction
  function automatic logic [31:0] rs_pc(input logic [4:0] id);
    return 32'(id) << 2;
  endfunction
  function automatic logic [31:0] ls_data(input logic [4:0] id);
    return 32'(id) * 32'h0100_0001;
  endfunction

  function automatic int cc_of(input int v);
`ifdef CDB_CONFLICT_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic vec_t mk(input logic rdy, rb, rsv, input logic [4:0] rsid,
                              input logic lsv, input logic [4:0] lsid,
                              input logic ev, input logic [4:0] eid,
                              input logic els, efr, efl, input int ecc);
    vec_t v;
    v.rdy = rdy; v.rb = rb; v.rsv = rsv; v.rsid = rsid; v.lsv = lsv; v.lsid = lsid;
    v.ev = ev; v.eid = eid; v.els = els; v.efr = efr; v.efl = efl; v.ecc = ecc;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic ev, input logic [4:0] eid,
                     input logic [31:0] ed, input logic [31:0] epc, input logic ej,
                     input logic els, input logic efr, input logic efl);
    cmp({nm, ".valid"},   32'(bus.cdb_valid), 32'(ev));
    cmp({nm, ".rob_id"},  32'(bus.cdb_rob_id), 32'(eid));
    cmp({nm, ".data"},    bus.cdb_data, ed);
    cmp({nm, ".pc"},      bus.cdb_jump_target_pc, epc);
    cmp({nm, ".jump"},    32'(bus.cdb_jump_sign), 32'(ej));
    cmp({nm, ".from_ls"}, 32'(bus.cdb_from_ls), 32'(els));
    cmp({nm, ".full_rs"}, 32'(bus.full_to_rs), 32'(efr));
    cmp({nm, ".full_ls"}, 32'(bus.full_to_ls), 32'(efl));
    cmp({nm, ".conflict"}, bus.conflict_cnt, 32'(cc_of(exp_cc)));
  endtask

  // Expected broadcast fields for a held/loaded entry identified by id and source.
  task automatic chk_id(input string nm, input logic ev, input logic [4:0] eid,
                        input logic els, input logic efr, input logic efl);
    chk(nm, ev, eid, els ? ls_data(eid) : rs_data(eid),
        els ? 32'h0 : rs_pc(eid), els ? 1'b0 : eid[0], els, efr, efl);
  endtask

  task automatic drive(input logic rdy, input logic rb,
                       input logic rsv, input logic [4:0] rsid, input logic [31:0] rsd,
                       input logic [31:0] rspc, input logic rsj,
                       input logic lsv, input logic [4:0] lsid, input logic [31:0] lsd);
    bus.rdy = rdy;
    bus.rollback_sign = rb;
    bus.valid_from_rs_ex = rsv;
    bus.rob_id_from_rs_ex = rsid;
    bus.data_from_rs_ex = rsd;
    bus.jump_target_pc_from_rs_ex = rspc;
    bus.jump_sign_from_rs_ex = rsj;
    bus.valid_from_ls_ex = lsv;
    bus.rob_id_from_ls_ex = lsid;
    bus.data_from_ls_ex = lsd;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rdy, input logic rb, input logic rsv, input logic [4:0] rsid,
                      input logic lsv, input logic [4:0] lsid);
    drive(rdy, rb, rsv, rsid, rs_data(rsid), rs_pc(rsid), rsid[0], lsv, lsid, ls_data(lsid));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  initial begin
    // Table: ordering/fairness, invalid tag, rollback, then fill to drop and drain.
    //            rdy rb rsv rsid lsv lsid   ev eid els frs fls cc
    tbl.push_back(mk(1, 0, 1, 1,  1, 2,    0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 4,  1, 5,    1, 1,  0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    1, 2,  1, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    1, 4,  0, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    1, 5,  1, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    0, 5,  1, 0, 0, 3));
    tbl.push_back(mk(1, 0, 1, 0,  1, 0,    0, 5,  1, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    0, 5,  1, 0, 0, 3));
    tbl.push_back(mk(1, 1, 1, 9,  1, 9,    0, 5,  1, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    0, 5,  1, 0, 0, 3));
    tbl.push_back(mk(1, 0, 1, 1,  1, 11,   0, 5,  1, 0, 0, 3));
    tbl.push_back(mk(1, 0, 1, 2,  1, 12,   1, 1,  0, 0, 0, 4));
    tbl.push_back(mk(1, 0, 1, 3,  1, 13,   1, 11, 1, 0, 0, 5));
    tbl.push_back(mk(1, 0, 1, 4,  1, 14,   1, 2,  0, 0, 1, 6));
    tbl.push_back(mk(1, 0, 1, 5,  1, 15,   1, 12, 1, 1, 1, 7));
    tbl.push_back(mk(1, 0, 1, 6,  1, 16,   1, 3,  0, 1, 1, 8));
    tbl.push_back(mk(1, 0, 1, 7,  1, 17,   1, 13, 1, 1, 1, 9));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    1, 4,  0, 1, 1, 10));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    1, 14, 1, 1, 0, 11));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    1, 5,  0, 0, 0, 12));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    1, 15, 1, 0, 0, 13));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    1, 6,  0, 0, 0, 14));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    1, 16, 1, 0, 0, 15));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    1, 7,  0, 0, 0, 15));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,    0, 7,  0, 0, 0, 15));

    // Reset state.
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    exp_cc = 0;
    chk("reset", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].rdy, tbl[i].rb, tbl[i].rsv, tbl[i].rsid, tbl[i].lsv, tbl[i].lsid);
      exp_cc = tbl[i].ecc;
      chk_id($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eid, tbl[i].els, tbl[i].efr, tbl[i].efl);
    end

    // Single RS result with fixed payload: one-edge queueing, broadcast next edge.
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h12, 32'h100, 1'b1, 1'b0, 5'd0, 32'h0);
    chk_id("single.push", 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
    idle();
    chk("single.bcast", 1'b1, 5'd3, 32'h12, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk("single.hold", 1'b0, 5'd3, 32'h12, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);

    // Three queued entries then rollback: nothing broadcast, queues empty.
    step(1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2);
    chk("rb.fill0", 1'b0, 5'd3, 32'h12, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 5'd4);
    exp_cc = 16;
    chk_id("rb.fill1", 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd6);
    chk_id("rb.flush", 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
    idle();
    chk_id("rb.empty", 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6);
    chk_id("rb.newpush", 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
    idle();
    chk_id("rb.newbcast", 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);

    // rdy low freezes a live broadcast and drops that cycle's inputs.
    step(1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 5'd9);
    chk_id("frz.push", 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    idle();
    exp_cc = 17;
    chk_id("frz.bcast", 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 5'd11, 1'b1, 5'd10);
      chk_id($sformatf("frz.low%0d", k), 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    end
    idle();
    chk_id("frz.resume", 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    idle();
    chk_id("frz.lost", 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);

    // Mid-operation reset with both queues near full; rst beats rdy/rollback.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 5'(20 + k), 1'b1, 5'(25 + k));
    cmp("mrst.pre_full_rs", 32'(bus.full_to_rs), 32'd1);
    cmp("mrst.pre_full_ls", 32'(bus.full_to_ls), 32'd1);
    cmp("mrst.pre_conflict", bus.conflict_cnt, 32'(cc_of(21)));
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1, 5'd30, 1'b1, 5'd31);
    exp_cc = 0;
    chk("mrst.reset", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle();
    chk("mrst.idle0", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("mrst.idle1", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
